// File: rtl/cheri_sram_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals around the CHERIoT SRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/SRAM view.
interface cheri_sram_arbiter_if #(
  parameter int AddrWidth = 14
);
  logic                 instr_req_i;
  logic                 instr_gnt_o;
  logic [31:0]          instr_addr_i;
  logic                 instr_rvalid_o;
  logic [64:0]          instr_rdata_o;
  logic                 instr_err_o;

  logic                 data_req_i;
  logic                 data_gnt_o;
  logic                 data_we_i;
  logic                 data_is_cap_i;
  logic [3:0]           data_be_i;
  logic [31:0]          data_addr_i;
  logic [64:0]          data_wdata_i;
  logic                 data_rvalid_o;
  logic [64:0]          data_rdata_o;
  logic                 data_err_o;

  logic                 tsmap_cs_i;
  logic [AddrWidth-1:0] tsmap_addr_i;
  logic [64:0]          tsmap_rdata_o;

  logic                 mem_cs_o;
  logic                 mem_we_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [7:0]           mem_be_o;
  logic                 mem_tag_we_o;
  logic [64:0]          mem_wdata_o;
  logic [64:0]          mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_is_cap_i, data_be_i, data_addr_i, data_wdata_i,
    input  tsmap_cs_i, tsmap_addr_i, mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output tsmap_rdata_o,
    output mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_tag_we_o, mem_wdata_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_is_cap_i, data_be_i, data_addr_i, data_wdata_i,
    output tsmap_cs_i, tsmap_addr_i, mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  tsmap_rdata_o,
    input  mem_cs_o, mem_we_o, mem_addr_o, mem_be_o, mem_tag_we_o, mem_wdata_o
  );
endinterface

// File: rtl/cheri_sram_arbiter.sv
// Shares one 65-bit single-port SRAM between instruction fetch, data and TS map ports,
// with tag-write policy, anti-starvation priority and one-cycle response routing.
module cheri_sram_arbiter #(
  parameter logic [31:0] MemBase     = 32'h200f_0000,
  parameter int          AddrWidth   = 14,
  parameter int          StarveLimit = 4
) (
  input logic                     clk_i,
  input logic                     rstn_i,
  cheri_sram_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA,
    OWN_TSMAP
  } owner_e;

  // Window end computed in 33 bits so a window touching 4 GiB cannot wrap.
  localparam logic [32:0] WinEnd    = {1'b0, MemBase} + (33'd8 << AddrWidth);
  localparam logic [3:0]  StarveThr = 4'(StarveLimit);

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, MemBase}) && ({1'b0, a} < WinEnd);
  endfunction

  function automatic logic [AddrWidth-1:0] word_of(input logic [31:0] a);
    return AddrWidth'((a - MemBase) >> 3);
  endfunction

  owner_e     owner_q, owner_d;
  logic       err_q, err_d;
  logic       we_q, we_d;
  logic [3:0] starve_cnt;
  logic       instr_wins;
  logic       instr_hit, data_hit, cap_misaligned;

  assign instr_wins     = starve_cnt >= StarveThr;
  assign instr_hit      = in_window(bus.instr_addr_i);
  assign data_hit       = in_window(bus.data_addr_i);
  assign cap_misaligned = bus.data_we_i && bus.data_is_cap_i && (bus.data_addr_i[2:0] != 3'b000);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner_q    <= OWN_NONE;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      owner_q <= owner_d;
      err_q   <= err_d;
      we_q    <= we_d;
      if (!bus.instr_req_i || bus.instr_gnt_o) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != 4'hF) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // A winner that fails decode still owns the slot but leaves the SRAM idle.
  always_comb begin
    bus.instr_gnt_o  = 1'b0;
    bus.data_gnt_o   = 1'b0;
    bus.mem_cs_o     = 1'b0;
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_be_o     = 8'h00;
    bus.mem_tag_we_o = 1'b0;
    bus.mem_wdata_o  = '0;
    owner_d          = OWN_NONE;
    err_d            = 1'b0;
    we_d             = 1'b0;

    if (bus.tsmap_cs_i) begin
      owner_d        = OWN_TSMAP;
      bus.mem_cs_o   = 1'b1;
      bus.mem_addr_o = bus.tsmap_addr_i;
      bus.mem_be_o   = 8'hFF;
    end else if (bus.instr_req_i && (!bus.data_req_i || instr_wins)) begin
      bus.instr_gnt_o = 1'b1;
      owner_d         = OWN_INSTR;
      if (instr_hit) begin
        bus.mem_cs_o   = 1'b1;
        bus.mem_addr_o = word_of(bus.instr_addr_i);
        bus.mem_be_o   = 8'hFF;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.data_req_i) begin
      bus.data_gnt_o = 1'b1;
      owner_d        = OWN_DATA;
      we_d           = bus.data_we_i;
      if (!data_hit || cap_misaligned) begin
        err_d = 1'b1;
      end else begin
        bus.mem_cs_o   = 1'b1;
        bus.mem_we_o   = bus.data_we_i;
        bus.mem_addr_o = word_of(bus.data_addr_i);
        bus.mem_be_o   = 8'hFF;
        if (bus.data_we_i) begin
          bus.mem_tag_we_o = 1'b1;
          if (bus.data_is_cap_i) begin
            bus.mem_wdata_o = bus.data_wdata_i;
          end else begin
            // Narrow writes replicate into both halves and always clear the tag.
            bus.mem_be_o    = bus.data_addr_i[2] ? {bus.data_be_i, 4'h0} : {4'h0, bus.data_be_i};
            bus.mem_wdata_o = {1'b0, bus.data_wdata_i[31:0], bus.data_wdata_i[31:0]};
          end
        end
      end
    end
  end

  assign bus.instr_rvalid_o = (owner_q == OWN_INSTR);
  assign bus.instr_err_o    = (owner_q == OWN_INSTR) && err_q;
  assign bus.instr_rdata_o  = ((owner_q == OWN_INSTR) && !err_q) ? bus.mem_rdata_i : '0;

  assign bus.data_rvalid_o  = (owner_q == OWN_DATA);
  assign bus.data_err_o     = (owner_q == OWN_DATA) && err_q;
  assign bus.data_rdata_o   = ((owner_q == OWN_DATA) && !err_q && !we_q) ? bus.mem_rdata_i : '0;

  assign bus.tsmap_rdata_o  = (owner_q == OWN_TSMAP) ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_cheri_sram_arbiter.sv
// Table-driven bench for cheri_sram_arbiter: one row per clock cycle, each row
// holds the inputs for that cycle and the outputs expected in the same cycle.
module tb_cheri_sram_arbiter;

  typedef struct packed {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic        dcap;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [64:0] dwdata;
    logic        tcs;
    logic [13:0] taddr;
    logic [64:0] mrdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_cs;
    logic        e_we;
    logic [13:0] e_addr;
    logic [7:0]  e_be;
    logic        e_tagwe;
    logic [64:0] e_wdata;
    logic        e_irv;
    logic        e_ierr;
    logic [64:0] e_irdata;
    logic        e_drv;
    logic        e_derr;
    logic [64:0] e_drdata;
    logic [64:0] e_trdata;
  } vec_t;

  localparam logic [64:0] WordA = 65'h1_DEAD_BEEF_CAFE_F00D;
  localparam logic [64:0] Junk  = 65'h0_1111_2222_3333_4444;
  localparam logic [64:0] WordT = 65'h1_5555_6666_7777_8888;
  localparam logic [64:0] WordS = 65'h0_0000_0000_0000_005A;
  localparam logic [64:0] CapW  = 65'h1_AAAA_BBBB_CCCC_DDDD;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  vec_t tbl[$];

  cheri_sram_arbiter_if #(.AddrWidth(14)) bus ();

  cheri_sram_arbiter #(
    .MemBase    (32'h200f_0000),
    .AddrWidth  (14),
    .StarveLimit(4)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t r);
    bus.instr_req_i   = r.ireq;
    bus.instr_addr_i  = r.iaddr;
    bus.data_req_i    = r.dreq;
    bus.data_we_i     = r.dwe;
    bus.data_is_cap_i = r.dcap;
    bus.data_be_i     = r.dbe;
    bus.data_addr_i   = r.daddr;
    bus.data_wdata_i  = r.dwdata;
    bus.tsmap_cs_i    = r.tcs;
    bus.tsmap_addr_i  = r.taddr;
    bus.mem_rdata_i   = r.mrdata;
  endtask

  task automatic checkOutput(input string tag, input string name,
                             input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic checkRow(input string tag, input vec_t r);
    checkOutput(tag, "instr_gnt",    65'(bus.instr_gnt_o),    65'(r.e_igt));
    checkOutput(tag, "data_gnt",     65'(bus.data_gnt_o),     65'(r.e_dgt));
    checkOutput(tag, "mem_cs",       65'(bus.mem_cs_o),       65'(r.e_cs));
    checkOutput(tag, "mem_we",       65'(bus.mem_we_o),       65'(r.e_we));
    checkOutput(tag, "mem_addr",     65'(bus.mem_addr_o),     65'(r.e_addr));
    checkOutput(tag, "mem_be",       65'(bus.mem_be_o),       65'(r.e_be));
    checkOutput(tag, "mem_tag_we",   65'(bus.mem_tag_we_o),   65'(r.e_tagwe));
    checkOutput(tag, "mem_wdata",    bus.mem_wdata_o,         r.e_wdata);
    checkOutput(tag, "instr_rvalid", 65'(bus.instr_rvalid_o), 65'(r.e_irv));
    checkOutput(tag, "instr_err",    65'(bus.instr_err_o),    65'(r.e_ierr));
    checkOutput(tag, "instr_rdata",  bus.instr_rdata_o,       r.e_irdata);
    checkOutput(tag, "data_rvalid",  65'(bus.data_rvalid_o),  65'(r.e_drv));
    checkOutput(tag, "data_err",     65'(bus.data_err_o),     65'(r.e_derr));
    checkOutput(tag, "data_rdata",   bus.data_rdata_o,        r.e_drdata);
    checkOutput(tag, "tsmap_rdata",  bus.tsmap_rdata_o,       r.e_trdata);
  endtask

  function automatic vec_t idle(input logic [64:0] mr);
    vec_t r;
    r = '0;
    r.mrdata = mr;
    return r;
  endfunction

  function automatic vec_t dread(input logic [31:0] a, input logic [64:0] mr);
    vec_t r;
    r = idle(mr);
    r.dreq = 1'b1; r.daddr = a; r.dbe = 4'hF;
    return r;
  endfunction

  function automatic vec_t ireadr(input vec_t base, input logic [31:0] a);
    vec_t r;
    r = base;
    r.ireq = 1'b1; r.iaddr = a;
    return r;
  endfunction

  function automatic vec_t expRead(input vec_t base, input logic [13:0] a);
    vec_t r;
    r = base;
    r.e_cs = 1'b1; r.e_addr = a; r.e_be = 8'hFF;
    return r;
  endfunction

  task automatic runCycle(input string tag, input vec_t r);
    @(posedge clk);
    #1;
    applyStimulus(r);
    #4;
    checkRow(tag, r);
  endtask

  initial begin
    vec_t r;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    applyStimulus(idle(Junk));

    // Cycle rows; responses in a row belong to the grant of the previous row.
    r = idle('0);                                                   tbl.push_back(r);
    r = expRead(dread(32'h200f_0010, '0), 14'd2); r.e_dgt = 1;      tbl.push_back(r);
    r = idle(WordA); r.e_drv = 1; r.e_drdata = WordA;               tbl.push_back(r);
    r = idle('0); r.dreq = 1; r.dwe = 1; r.dbe = 4'b0011; r.daddr = 32'h200f_0004;
    r.dwdata = 65'h1_FFFF_FFFF_1234_5678;
    r.e_dgt = 1; r.e_cs = 1; r.e_we = 1; r.e_addr = 14'd0; r.e_be = 8'h30; r.e_tagwe = 1;
    r.e_wdata = 65'h0_1234_5678_1234_5678;                          tbl.push_back(r);
    r = idle(Junk); r.dreq = 1; r.dwe = 1; r.dbe = 4'b1100; r.daddr = 32'h200f_0000;
    r.dwdata = 65'h1_0000_0000_AABB_CCDD;
    r.e_dgt = 1; r.e_cs = 1; r.e_we = 1; r.e_addr = 14'd0; r.e_be = 8'h0C; r.e_tagwe = 1;
    r.e_wdata = 65'h0_AABB_CCDD_AABB_CCDD; r.e_drv = 1;             tbl.push_back(r);
    r = idle(Junk); r.dreq = 1; r.dwe = 1; r.dcap = 1; r.daddr = 32'h200f_0008; r.dwdata = CapW;
    r.e_dgt = 1; r.e_cs = 1; r.e_we = 1; r.e_addr = 14'd1; r.e_be = 8'hFF; r.e_tagwe = 1;
    r.e_wdata = CapW; r.e_drv = 1;                                  tbl.push_back(r);
    r = idle(Junk); r.dreq = 1; r.dwe = 1; r.dcap = 1; r.daddr = 32'h200f_0004; r.dwdata = CapW;
    r.e_dgt = 1; r.e_drv = 1;                                       tbl.push_back(r);
    r = idle(Junk); r.e_drv = 1; r.e_derr = 1;                      tbl.push_back(r);
    r = ireadr(idle('0), 32'h1000_0000); r.e_igt = 1;               tbl.push_back(r);
    r = idle(65'h5); r.e_irv = 1; r.e_ierr = 1;                     tbl.push_back(r);
    r = expRead(ireadr(idle('0), 32'h200f_0018), 14'd3); r.e_igt = 1; tbl.push_back(r);
    r = idle(65'h0_0000_0013_0000_0093); r.e_irv = 1; r.e_irdata = 65'h0_0000_0013_0000_0093;
    tbl.push_back(r);
    r = expRead(dread(32'h200f_0020, '0), 14'h1234); r.tcs = 1; r.taddr = 14'h1234;
    tbl.push_back(r);
    r = expRead(dread(32'h200f_0020, WordT), 14'd4); r.e_dgt = 1; r.e_trdata = WordT;
    tbl.push_back(r);
    r = idle(WordA); r.e_drv = 1; r.e_drdata = WordA;               tbl.push_back(r);

    // Both ports held: data wins four times, instr on the fifth, then data again.
    for (int i = 0; i < 6; i++) begin
      r = ireadr(dread(32'h200f_0020, WordS), 32'h200f_0018);
      if (i == 4) begin
        r = expRead(r, 14'd3); r.e_igt = 1;
      end else begin
        r = expRead(r, 14'd4); r.e_dgt = 1;
      end
      if (i >= 1 && i <= 4) begin r.e_drv = 1; r.e_drdata = WordS; end
      if (i == 5) begin r.e_irv = 1; r.e_irdata = WordS; end
      tbl.push_back(r);
    end
    r = idle(WordS); r.e_drv = 1; r.e_drdata = WordS;               tbl.push_back(r);

    // Losing to the TS map also counts toward starvation.
    for (int i = 0; i < 4; i++) begin
      r = expRead(ireadr(dread(32'h200f_0020, WordS), 32'h200f_0018), 14'h0ABC);
      r.tcs = 1; r.taddr = 14'h0ABC;
      if (i > 0) r.e_trdata = WordS;
      tbl.push_back(r);
    end
    r = expRead(ireadr(dread(32'h200f_0020, WordS), 32'h200f_0018), 14'd3);
    r.e_igt = 1; r.e_trdata = WordS;                                tbl.push_back(r);
    r = idle(WordA); r.e_irv = 1; r.e_irdata = WordA;               tbl.push_back(r);

    // Window edges.
    r = expRead(dread(32'h2010_fff8, '0), 14'h3FFF); r.e_dgt = 1;   tbl.push_back(r);
    r = dread(32'h2011_0000, WordS); r.e_dgt = 1; r.e_drv = 1; r.e_drdata = WordS;
    tbl.push_back(r);
    r = dread(32'h200e_fff8, WordS); r.e_dgt = 1; r.e_drv = 1; r.e_derr = 1;
    tbl.push_back(r);
    r = idle(WordS); r.e_drv = 1; r.e_derr = 1;                     tbl.push_back(r);

    #23;
    checkRow("in_reset", idle(Junk));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #4;
    checkRow("after_release", idle(Junk));

    foreach (tbl[i]) runCycle($sformatf("row%0d", i), tbl[i]);

    // Reset asserted in the response cycle must swallow the pending rvalid.
    r = expRead(dread(32'h200f_0030, '0), 14'd6); r.e_dgt = 1;
    runCycle("rst_grant", r);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    applyStimulus(idle(WordA));
    #4;
    checkRow("rst_drop", idle(WordA));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    runCycle("rst_first", idle(WordA));
    r = expRead(dread(32'h200f_0010, '0), 14'd2); r.e_dgt = 1;
    runCycle("rst_again", r);
    r = idle(WordT); r.e_drv = 1; r.e_drdata = WordT;
    runCycle("rst_again_rsp", r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
